// File: rtl/fft_bf_ctrl.sv
// Sequencer for a 16-lane radix-2 butterfly stage over 512-point frames (FILL half / CALC half / drain).
// Latency: strobes are combinational with the step; valid_out/sof_out/eof_out follow one cycle later.
// Backpressure: out_ready stalls CALC and drain; in_ready stops a fill from overwriting an undrained entry.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   valid_in / in_ready       input beat handshake (fire = valid_in & in_ready)
//   out_ready                 downstream accepts an output beat
//   abort                     synchronous frame abort, wins over fire
//   bf_en                     butterfly computes this step
//   buf_wr_en/buf_waddr       delay-buffer write; wr_sel: 0 raw input, 1 do2 result
//   buf_rd_en/buf_raddr       delay-buffer read (read-before-write on same address)
//   out_sel                   0 do1 to output, 1 buffer drain to output
//   tw_idx                    twiddle base, lane j uses tw_idx + j
//   valid_out/sof_out/eof_out registered output beat markers
// Optional build macro FFT_CTRL_STATS_EN adds frame_cnt and stall_cnt (16-bit, wrapping).

module fft_bf_ctrl #(
    parameter int NUM   = 16,
    parameter int DATA  = 512,
    parameter int BEATS = DATA / NUM,
    parameter int HALF  = BEATS / 2,
    parameter int AW    = $clog2(HALF),
    parameter int TW_W  = $clog2(DATA / 2)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_in,
    output logic            in_ready,
    input  logic            out_ready,
    input  logic            abort,
    output logic            bf_en,
    output logic            buf_wr_en,
    output logic [AW-1:0]   buf_waddr,
    output logic            wr_sel,
    output logic            buf_rd_en,
    output logic [AW-1:0]   buf_raddr,
    output logic            out_sel,
    output logic [TW_W-1:0] tw_idx,
    output logic            valid_out,
    output logic            sof_out,
    output logic            eof_out
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int BW = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CALC = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] b, b_nxt;          // beat within frame
    logic [AW-1:0] d, d_nxt;          // drain pointer into the delay buffer
    logic          drain_pend, drain_pend_nxt;
    logic          vo_nxt, sof_nxt, eof_nxt;
    logic          fire, drain_step;

    logic [AW-1:0] b_lo;              // b mod HALF: buffer address in both halves
    logic [BW-1:0] d_ext;

    assign b_lo  = b[AW-1:0];
    assign d_ext = BW'(d);

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            b          <= '0;
            d          <= '0;
            drain_pend <= 1'b0;
            valid_out  <= 1'b0;
            sof_out    <= 1'b0;
            eof_out    <= 1'b0;
        end else begin
            state      <= state_nxt;
            b          <= b_nxt;
            d          <= d_nxt;
            drain_pend <= drain_pend_nxt;
            valid_out  <= vo_nxt;
            sof_out    <= sof_nxt;
            eof_out    <= eof_nxt;
        end
    end

    // Next state, step strobes and buffer control
    always_comb begin
        state_nxt      = state;
        b_nxt          = b;
        d_nxt          = d;
        drain_pend_nxt = drain_pend;
        vo_nxt         = 1'b0;
        sof_nxt        = 1'b0;
        eof_nxt        = 1'b0;
        fire           = 1'b0;
        drain_step     = 1'b0;
        in_ready       = 1'b1;
        bf_en          = 1'b0;
        buf_wr_en      = 1'b0;
        buf_waddr      = '0;
        wr_sel         = 1'b0;
        buf_rd_en      = 1'b0;
        buf_raddr      = '0;
        out_sel        = 1'b0;
        tw_idx         = '0;

        case (state)
            IDLE, FILL: begin
                // The fill pointer may only write an entry the drain has
                // already read (b < d), or the one it reads this very cycle.
                in_ready   = ~drain_pend | (b < d_ext) | ((b == d_ext) & out_ready);
                fire       = valid_in & in_ready & ~abort;
                drain_step = drain_pend & out_ready & ~abort;

                if (fire) begin
                    buf_wr_en = 1'b1;
                    buf_waddr = b_lo;
                    wr_sel    = 1'b0;
                    b_nxt     = b + 1'b1;
                    state_nxt = (b == BW'(HALF - 1)) ? CALC : FILL;
                end

                // Drain runs regardless of valid_in so a gap still empties the buffer.
                if (drain_step) begin
                    buf_rd_en = 1'b1;
                    buf_raddr = d;
                    out_sel   = 1'b1;
                    vo_nxt    = 1'b1;
                    if (d == AW'(HALF - 1)) begin
                        eof_nxt        = 1'b1;
                        d_nxt          = '0;
                        drain_pend_nxt = 1'b0;
                    end else begin
                        d_nxt = d + 1'b1;
                    end
                end
            end

            CALC: begin
                in_ready = out_ready;
                fire     = valid_in & in_ready & ~abort;
                tw_idx   = TW_W'(b_lo) * TW_W'(NUM);

                if (fire) begin
                    bf_en     = 1'b1;
                    buf_rd_en = 1'b1;
                    buf_raddr = b_lo;
                    buf_wr_en = 1'b1;
                    buf_waddr = b_lo;
                    wr_sel    = 1'b1;
                    out_sel   = 1'b0;
                    vo_nxt    = 1'b1;
                    sof_nxt   = (b == BW'(HALF));
                    if (b == BW'(BEATS - 1)) begin
                        b_nxt          = '0;
                        drain_pend_nxt = 1'b1;
                        state_nxt      = FILL;
                    end else begin
                        b_nxt = b + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort) begin
            state_nxt      = IDLE;
            b_nxt          = '0;
            d_nxt          = '0;
            drain_pend_nxt = 1'b0;
        end
    end

`ifdef FFT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else if (abort) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (eof_nxt) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (valid_in & ~in_ready) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fft_bf_ctrl.md
Name: fft_bf_ctrl

Overview:
- Sequencing controller for the 16-lane radix-2 butterfly stage operating on 512-point frames (32 beats of 16 samples).
- Splits each frame into a FILL half (beats 0..15 stored in a 16-entry delay buffer) and a CALC half (beats 16..31 paired with the buffered beats; do1 emitted, do2 written back).
- Drains the stored do2 results while the next frame fills, and generates twiddle indices, buffer addresses, output mux select and frame markers.
- Sits between the sample source and the butterfly/delay-buffer datapath, with ready/valid backpressure from downstream.

Parameters:
- NUM, 16, lanes per beat
- DATA, 512, points per frame
- BEATS, DATA/NUM (32), beats per frame; HALF = BEATS/2 = 16
- AW, $clog2(HALF) (4), buffer address width
- TW_W, $clog2(DATA/2) (8), twiddle index width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- valid_in  in  1  input beat valid
- in_ready  out  1  controller accepts a beat; fire = valid_in & in_ready
- out_ready  in  1  downstream accepts an output beat
- abort  in  1  synchronous frame abort
- bf_en  out  1  butterfly computes this step (CALC)
- buf_wr_en  out  1  delay-buffer write
- buf_waddr  out  AW  write address
- wr_sel  out  1  0 = raw input to buffer, 1 = do2 result to buffer
- buf_rd_en  out  1  delay-buffer read
- buf_raddr  out  AW  read address
- out_sel  out  1  0 = do1 to output, 1 = buffer drain to output
- tw_idx  out  TW_W  twiddle base; lane j uses tw_idx + j
- valid_out  out  1  output beat valid (registered)
- sof_out  out  1  first output beat of a frame
- eof_out  out  1  last output beat of a frame

Behaviour:
- Reset values: state IDLE, b = 0, d = 0, drain_pend = 0. All outputs 0 except in_ready = 1.
- State register plus counters: b (beat in frame, 0..31), d (drain pointer, 0..15), drain_pend.
- Control outputs are combinational from the registered state and coincide with the step.
- valid_out, sof_out and eof_out are registered one cycle after the step, matching the butterfly output register.
- IDLE / FILL:
  - in_ready = ~drain_pend | (b < d) | (b == d & out_ready).
  - On fire: buf_wr_en = 1, waddr = b, wr_sel = 0, b++.
  - Fire with b == 15 moves the state to CALC.
  - IDLE becomes FILL on the first fire.
- Drain step (FILL with drain_pend & out_ready, independent of valid_in):
  - buf_rd_en = 1, raddr = d, out_sel = 1, d++.
  - valid_out is asserted the next cycle; sof_out is not asserted on drain beats.
  - eof_out is asserted on the drain beat with d == 15, which then clears drain_pend and sets d = 0.
  - A read and a write to the same address in one cycle return the old data (read-before-write).
- CALC:
  - in_ready = out_ready.
  - On fire: bf_en = 1; buf_rd_en = 1 and buf_wr_en = 1 at address b-16; wr_sel = 1; out_sel = 0; tw_idx = (b-16)*NUM; b++.
  - sof_out is asserted on the output of b == 16.
  - Fire with b == 31 sets b = 0, drain_pend = 1 and state FILL.
- tw_idx = 0 outside CALC.
- Output order per frame is 16 do1 beats followed by 16 do2 beats.
- A stall (out_ready = 0) freezes b, d and the state. A write that would overwrite an entry not yet drained is blocked by in_ready.
- Drain always completes before the next CALC starts, because b cannot pass d.
- abort: next cycle state IDLE, b = d = 0, drain_pend = 0, no valid_out. Abort has priority over fire.
- rstn deasserted mid-frame: immediate clear to reset values; partial output is discarded.

Optional Feature:
- Macro FFT_CTRL_STATS_EN.
- Defined: adds output ports frame_cnt[15:0] and stall_cnt[15:0].
  - frame_cnt increments when eof_out asserts.
  - stall_cnt increments each cycle valid_in & ~in_ready.
  - Both wrap at 0xFFFF and clear on rstn or abort.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single frame, valid_in held high 32 cycles, out_ready = 1:
  - beats 0..15 write addresses 0..15, wr_sel = 0.
  - beats 16..31 have bf_en = 1 and tw_idx = 0, 16, ..., 240.
  - 16 do1 valid_out, then 16 drain beats with raddr 0..15; sof_out on the first do1 beat, eof_out on drain beat 15.
- Back-to-back frames (64 consecutive valid beats): frame-2 fill overlaps frame-1 drain with no bubble; raddr = waddr each cycle; 64 valid_out in order.
- out_ready = 0 for 5 cycles at drain d = 4 while frame 2 is filling at b = 4:
  - in_ready drops; b and d hold.
  - Resume gives contiguous raddr 4, 5, ...; no data loss.
- Input gap after frame 1: 16 drain beats complete autonomously; state FILL, drain_pend = 0, in_ready = 1.
- abort asserted at CALC b = 20: next cycle IDLE, no further valid_out; a new frame then starts at waddr 0.
- rstn pulsed low at FILL b = 7: all outputs are at reset values during reset; the next frame behaves as in the single-frame scenario. With FFT_CTRL_STATS_EN, frame_cnt = 0 after reset and 2 after two frames.
